// File: rtl/lpcm_multi_sequencer_if.sv
// Sample-stream handshake between the LPCM multi-channel sequencer (master) and its driver (slave).
interface lpcm_multi_sequencer_if #(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 2,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_sample;
    logic [CW-1:0]    req_channel;
    logic             req_last;
    logic [7:0]       req_latency;

    modport master (output req_valid, req_sample, req_channel, req_last, req_latency,
                    input  req_ready);
    modport slave  (input  req_valid, req_sample, req_channel, req_last, req_latency,
                    output req_ready);
endinterface

// File: rtl/lpcm_multi_sequencer.sv
// Interleaved multi-channel LPCM generator (ramp/square/noise/constant), frame-counted runs.
// Define LPCM_SEQ_STATS_EN to add the stall_cycles / beats statistics outputs.
module lpcm_multi_sequencer #(
    parameter int WIDTH       = 24,
    parameter int CHANNELS    = 2,
    parameter int HALF_PERIOD = 16,
    parameter int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [15:0]            frames,
    input  logic [WIDTH-1:0]       step,
    input  logic [31:0]            seed,
    input  logic [7:0]             latency,
    lpcm_multi_sequencer_if.master req,
    output logic                   busy,
    output logic                   done
`ifdef LPCM_SEQ_STATS_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            beats
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [31:0]      TAPS    = 32'h8020_0003;
    localparam logic [CW-1:0]    LAST_CH = CW'(CHANNELS - 1);
    localparam int               HPW     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [HPW-1:0]   HP_LAST = HPW'(HALF_PERIOD - 1);
    localparam logic [WIDTH-1:0] SQ_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SQ_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [1:0]       mode_q;
    logic [15:0]      frames_q;
    logic [15:0]      frame_idx;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] ramp_base;
    logic [HPW-1:0]   hp_cnt;
    logic             phase;
    logic [31:0]      lfsr;

    logic             accept, final_beat, hp_wrap, nxt_ph;
    logic [CW-1:0]    nxt_ch;
    logic [WIDTH-1:0] nxt_base;
    logic [HPW-1:0]   nxt_hp;
    logic [31:0]      nxt_lfsr, seed_eff;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gen(input logic [1:0] md, input logic [WIDTH-1:0] base,
                                             input logic [CW-1:0] ch, input logic ph,
                                             input logic [WIDTH-1:0] noise, input logic [WIDTH-1:0] stp);
        case (md)
            2'd0:    return base + WIDTH'(ch);
            2'd1:    return ph ? SQ_NEG : SQ_POS;
            2'd2:    return noise;
            default: return stp;
        endcase
    endfunction

    // Next-beat values; ramp base and square phase only move at frame boundaries.
    always_comb begin
        accept     = req.req_valid && req.req_ready;
        final_beat = req.req_last && (frame_idx == frames_q - 16'd1);
        nxt_ch     = req.req_last ? '0 : req.req_channel + 1'b1;
        nxt_base   = req.req_last ? ramp_base + step_q : ramp_base;
        hp_wrap    = req.req_last && (hp_cnt == HP_LAST);
        nxt_hp     = !req.req_last ? hp_cnt : (hp_wrap ? '0 : hp_cnt + 1'b1);
        nxt_ph     = phase ^ hp_wrap;
        nxt_lfsr   = lfsr_step(lfsr);
        seed_eff   = (seed == 32'd0) ? 32'd1 : seed;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            mode_q          <= '0;
            frames_q        <= '0;
            frame_idx       <= '0;
            step_q          <= '0;
            ramp_base       <= '0;
            hp_cnt          <= '0;
            phase           <= 1'b0;
            lfsr            <= 32'd1;
            busy            <= 1'b0;
            done            <= 1'b0;
            req.req_valid   <= 1'b0;
            req.req_sample  <= '0;
            req.req_channel <= '0;
            req.req_last    <= 1'b0;
            req.req_latency <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    mode_q          <= mode;
                    frames_q        <= frames;
                    step_q          <= step;
                    req.req_latency <= latency;
                    frame_idx       <= '0;
                    ramp_base       <= '0;
                    hp_cnt          <= '0;
                    phase           <= 1'b0;
                    req.req_channel <= '0;
                    if (frames == 16'd0) begin
                        lfsr  <= seed_eff;
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        lfsr  <= lfsr_step(seed_eff);
                        state <= LOAD;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                LOAD: begin
                    req.req_sample  <= gen(mode_q, ramp_base, '0, phase, lfsr[31 -: WIDTH], step_q);
                    req.req_channel <= '0;
                    req.req_last    <= (LAST_CH == '0);
                    req.req_valid   <= 1'b1;
                    state           <= RUN;
                end
                RUN: if (accept) begin
                    lfsr <= nxt_lfsr;
                    if (final_beat) begin
                        req.req_valid <= 1'b0;
                        req.req_last  <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= DONE;
                    end else begin
                        frame_idx       <= frame_idx + 16'(req.req_last);
                        ramp_base       <= nxt_base;
                        hp_cnt          <= nxt_hp;
                        phase           <= nxt_ph;
                        req.req_channel <= nxt_ch;
                        req.req_last    <= (nxt_ch == LAST_CH);
                        req.req_sample  <= gen(mode_q, nxt_base, nxt_ch, nxt_ph,
                                               nxt_lfsr[31 -: WIDTH], step_q);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LPCM_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            beats        <= '0;
        end else if ((state == IDLE || state == DONE) && start) begin
            stall_cycles <= '0;
            beats        <= '0;
        end else begin
            if (req.req_valid && !req.req_ready && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (accept && beats != '1)
                beats <= beats + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_lpcm_multi_sequencer.sv
// Bench for lpcm_multi_sequencer: two instances (24b/2ch/HP16 and 16b/1ch/HP2) share one stimulus
// and are checked against an arithmetic reference model of the sample rules.
module tb_lpcm_multi_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b0;
    logic [1:0]  mode = '0;
    logic [15:0] frames = '0;
    logic [23:0] step = '0;
    logic [31:0] seed = '0;
    logic [7:0]  latency = '0, lat_q;
    logic        busy_a, done_a, busy_b, done_b;
    int          passed = 0, fails = 0, total = 0;
    logic [31:0] qa_s[$], qb_s[$];
    int          qa_c[$], qa_l[$], qb_c[$], qb_l[$];
    int          stalls_a, stalls_b, acc_a, acc_b, dcyc_a, dcyc_b, nbeat;
    bit          seen_valid;

    always #5 clk = ~clk;

    lpcm_multi_sequencer_if #(.WIDTH(24), .CHANNELS(2)) ifa ();
    lpcm_multi_sequencer_if #(.WIDTH(16), .CHANNELS(1)) ifb ();
    assign ifa.req_ready = ready;
    assign ifb.req_ready = ready;

`ifdef LPCM_SEQ_STATS_EN
    logic [31:0] stall_a, beats_a, stall_b, beats_b;
`endif

    lpcm_multi_sequencer #(.WIDTH(24), .CHANNELS(2), .HALF_PERIOD(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .frames(frames), .step(step),
        .seed(seed), .latency(latency), .req(ifa), .busy(busy_a), .done(done_a)
`ifdef LPCM_SEQ_STATS_EN
        , .stall_cycles(stall_a), .beats(beats_a)
`endif
    );

    lpcm_multi_sequencer #(.WIDTH(16), .CHANNELS(1), .HALF_PERIOD(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .frames(frames), .step(step[15:0]),
        .seed(seed), .latency(latency), .req(ifb), .busy(busy_b), .done(done_b)
`ifdef LPCM_SEQ_STATS_EN
        , .stall_cycles(stall_b), .beats(beats_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample n (0-based, across the whole run) for a w-bit, nch-channel, half-period hp build.
    function automatic logic [31:0] model(input int w, input int nch, input int hp, input int n);
        logic [31:0] mask, stp, lf;
        int f, c;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        stp  = 32'(step) & mask;
        f    = n / nch;
        c    = n % nch;
        case (mode)
            2'd0: return (32'(f) * stp + 32'(c)) & mask;
            2'd1: return ((f / hp) % 2 == 0) ? (mask >> 1) : ((mask >> 1) + 32'd1);
            2'd2: begin
                lf = (seed == 32'd0) ? 32'd1 : seed;
                for (int k = 0; k <= n; k++) lf = lf[0] ? ((lf >> 1) ^ 32'h8020_0003) : (lf >> 1);
                return lf >> (32 - w);
            end
            default: return stp;
        endcase
    endfunction

    // Pulse start at a falling edge, then collect accepted beats of both instances until both are done.
    task automatic run(input int rmode);
        int cyc;
        logic [31:0] pa_s, pb_s;
        int pa_c;
        logic pa_l;
        bit sa, sb;
        qa_s.delete(); qa_c.delete(); qa_l.delete();
        qb_s.delete(); qb_c.delete(); qb_l.delete();
        stalls_a = 0; stalls_b = 0; acc_a = -1; acc_b = -1; dcyc_a = -1; dcyc_b = -1;
        seen_valid = 0; sa = 0; sb = 0; pa_s = '0; pb_s = '0; pa_c = 0; pa_l = 1'b0;
        lat_q = latency;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        latency = ~latency;
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (done_a && dcyc_a < 0) dcyc_a = cyc;
            if (done_b && dcyc_b < 0) dcyc_b = cyc;
            if (done_a && done_b) break;
            if (ifa.req_valid || ifb.req_valid) seen_valid = 1;
            if (sa) begin
                chk("a_hold_sample", 32'(ifa.req_sample), pa_s);
                chk("a_hold_channel", 32'(ifa.req_channel), pa_c);
                chk("a_hold_last", 32'(ifa.req_last), 32'(pa_l));
            end
            if (sb) chk("b_hold_sample", 32'(ifb.req_sample), pb_s);
            ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            sa = ifa.req_valid && !ready;
            sb = ifb.req_valid && !ready;
            pa_s = 32'(ifa.req_sample); pa_c = int'(ifa.req_channel); pa_l = ifa.req_last;
            pb_s = 32'(ifb.req_sample);
            if (sa) stalls_a++;
            if (sb) stalls_b++;
            if (ifa.req_valid && ready) begin
                qa_s.push_back(32'(ifa.req_sample));
                qa_c.push_back(int'(ifa.req_channel));
                qa_l.push_back(int'(ifa.req_last));
                acc_a = cyc;
            end
            if (ifb.req_valid && ready) begin
                qb_s.push_back(32'(ifb.req_sample));
                qb_c.push_back(int'(ifb.req_channel));
                qb_l.push_back(int'(ifb.req_last));
                acc_b = cyc;
            end
            @(negedge clk);
        end
        if (cyc >= 3000) chk("run_timeout", 32'(cyc), 32'd0);
        ready = 1'b0;
    endtask

    task automatic check_streams();
        chk("a_beat_count", qa_s.size(), 2 * int'(frames));
        chk("b_beat_count", qb_s.size(), int'(frames));
        foreach (qa_s[i]) begin
            chk("a_sample", qa_s[i], model(24, 2, 16, i));
            chk("a_channel", qa_c[i], i % 2);
            chk("a_last", qa_l[i], i % 2);
        end
        foreach (qb_s[i]) begin
            chk("b_sample", qb_s[i], model(16, 1, 2, i));
            chk("b_channel", qb_c[i], 0);
            chk("b_last", qb_l[i], 1);
        end
        chk("a_done_delay", dcyc_a - acc_a, 1);
        chk("b_done_delay", dcyc_b - acc_b, 1);
        chk("a_latency", 32'(ifa.req_latency), 32'(lat_q));
        chk("b_latency", 32'(ifb.req_latency), 32'(lat_q));
        chk("a_busy_after", 32'(busy_a), 0);
`ifdef LPCM_SEQ_STATS_EN
        chk("a_stall_cycles", stall_a, stalls_a);
        chk("b_stall_cycles", stall_b, stalls_b);
        chk("a_beats", beats_a, qa_s.size());
        chk("b_beats", beats_b, qb_s.size());
`endif
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_a_valid"}, 32'(ifa.req_valid), 0);
        chk({tag, "_a_last"}, 32'(ifa.req_last), 0);
        chk({tag, "_a_sample"}, 32'(ifa.req_sample), 0);
        chk({tag, "_a_channel"}, 32'(ifa.req_channel), 0);
        chk({tag, "_a_latency"}, 32'(ifa.req_latency), 0);
        chk({tag, "_a_busy"}, 32'(busy_a), 0);
        chk({tag, "_a_done"}, 32'(done_a), 0);
        chk({tag, "_b_valid"}, 32'(ifb.req_valid), 0);
        chk({tag, "_b_sample"}, 32'(ifb.req_sample), 0);
        chk({tag, "_b_busy"}, 32'(busy_b), 0);
        chk({tag, "_b_done"}, 32'(done_b), 0);
    endtask

    initial begin
        logic [31:0] ramp_exp [6];
        logic [31:0] sq_exp [5];
        ramp_exp = '{32'h000, 32'h001, 32'h100, 32'h101, 32'h200, 32'h201};
        sq_exp   = '{32'h7FFF, 32'h7FFF, 32'h8000, 32'h8000, 32'h7FFF};

        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp, ready high, then the same stream under 1,0,0 backpressure.
        mode = 2'd0; frames = 16'd3; step = 24'h100; seed = 32'd1; latency = 8'h5A;
        run(0);
        check_streams();
        foreach (ramp_exp[i]) if (qa_s.size() == 6) chk("ramp_table", qa_s[i], ramp_exp[i]);
        run(1);
        check_streams();

        mode = 2'd1; frames = 16'd5;
        run(0);
        check_streams();
        foreach (sq_exp[i]) if (qb_s.size() == 5) chk("square_table", qb_s[i], sq_exp[i]);

        // Noise from a zero seed must follow the seed-1 sequence.
        mode = 2'd2; seed = 32'd0; frames = 16'd100;
        run(0);
        check_streams();

        mode = 2'd0; frames = 16'd0;
        run(2);
        chk("zero_done_cycle", dcyc_a, 0);
        chk("zero_no_valid", 32'(seen_valid), 0);
        chk("zero_beats", qa_s.size(), 0);
        frames = 16'd1; step = 24'($urandom);
        run(2);
        check_streams();

        for (int t = 0; t < 8; t++) begin
            mode = 2'($urandom_range(0, 3));
            frames = 16'($urandom_range(1, 12));
            step = 24'($urandom);
            seed = $urandom;
            run(2);
            check_streams();
        end

        // Reset asserted mid-cycle while beat 3 (frame 1, channel 1) is presented.
        mode = 2'd0; frames = 16'd4; step = 24'h10; latency = 8'h33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; ready = 1'b1; nbeat = 0;
        for (int i = 0; i < 20; i++) begin
            if (ifa.req_valid && nbeat == 3) break;
            if (ifa.req_valid) nbeat++;
            @(negedge clk);
        end
        chk("pre_reset_beat", 32'(ifa.req_sample), 32'h11);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        chk_reset_vals("midrst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 32'(ifa.req_valid), 0);
        run(0);
        check_streams();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
